// File: rtl/qspi_sram_burst_writer_pkg.sv
// Shared constants, state encoding and small helpers for the QPI SRAM burst writer.
// Opcodes and phase lengths describe the external QPI SRAM protocol.
package qspi_sram_burst_writer_pkg;

  localparam logic [7:0] QPI_WR = 8'h38;
  localparam logic [7:0] QPI_RD = 8'hEB;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_NIBS = 6;
  localparam int WORD_NIBS = 8;
  localparam int MAX_WORDS = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_CSHI
  } state_e;

  // A burst is only launched for counts the capture buffer can actually hold.
  function automatic logic cnt_valid(input logic [9:0] n);
    return (n != 10'd0) && (n <= 10'(MAX_WORDS));
  endfunction

endpackage

// File: rtl/qspi_sram_burst_writer_sck_gen.sv
// SPI clock generator: CLK_DIV cycles low then CLK_DIV cycles high while enabled.
// Strobes are asserted in the cycle before the matching SCK edge becomes visible.
module qspi_sram_burst_writer_sck_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          half_end;

  assign half_end = (cnt_q == CW'(CLK_DIV - 1));

  // Disabled generator parks low with a fresh half-period count.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (half_end) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o  = sck_q;
  assign rise_o = en_i && half_end && !sck_q;
  assign fall_o = en_i && half_end && sck_q;

endmodule

// File: rtl/qspi_sram_burst_writer.sv
// Streams capture-buffer words to a quad-SPI SRAM as one QPI write burst
// (opcode, 24-bit address, N x 32-bit words) and pulses done_o when finished.
module qspi_sram_burst_writer
  import qspi_sram_burst_writer_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int CS_HI   = 2
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  input  logic        start_i,
  input  logic [23:0] base_addr_i,
  input  logic [9:0]  word_cnt_i,
  output logic [8:0]  buf_ra_o,
  input  logic [31:0] buf_rd_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        qspi_ce_n_o,
  output logic        qspi_sck_o,
  output logic [3:0]  qspi_oe_o,
  output logic [3:0]  qspi_dat_o
);

  localparam int HW = $clog2(CS_HI + 1);

  state_e        state_q, state_d;
  logic          ce_n_q, ce_n_d;
  logic [3:0]    oe_q, oe_d;
  logic [3:0]    dat_q, dat_d;
  logic [8:0]    ra_q, ra_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [9:0]    left_q, left_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [31:0]   sr_q, sr_d;
  logic [23:0]   addr_q, addr_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          sck_rise, sck_fall;

  qspi_sram_burst_writer_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck (
    .clk_i  (WBs_CLK_i),
    .rst_i  (WBs_RST_i),
    .en_i   (~ce_n_q),
    .sck_o  (qspi_sck_o),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i && cnt_valid(word_cnt_i)) state_d = ST_LOAD;
      ST_LOAD: if (cnt_q != 3'd0) state_d = ST_CMD;
      ST_CMD:  if (sck_fall && cnt_q == 3'(CMD_BITS - 1)) state_d = ST_ADDR;
      ST_ADDR: if (sck_fall && cnt_q == 3'(ADDR_NIBS - 1)) state_d = ST_DATA;
      ST_DATA: if (sck_fall && cnt_q == 3'(WORD_NIBS - 1) && left_q == 10'd1) state_d = ST_CSHI;
      ST_CSHI: if (hold_q == HW'(CS_HI - 1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Every IO change happens at phase entry or on an SCK fall, so the SRAM
  // always samples settled data on the following rise.
  always_comb begin
    ce_n_d = ce_n_q;
    oe_d   = oe_q;
    dat_d  = dat_q;
    ra_d   = ra_q;
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    left_d = left_q;
    hold_d = hold_q;
    sr_d   = sr_q;
    addr_d = addr_q;
    cmd_d  = cmd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (cnt_valid(word_cnt_i)) begin
            busy_d = 1'b1;
            ra_d   = '0;
            cnt_d  = '0;
            left_d = word_cnt_i;
            addr_d = base_addr_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        // First cycle presents ra=0; the buffer answers one cycle later.
        if (cnt_q == 3'd0) begin
          cnt_d = 3'd1;
        end else begin
          sr_d   = buf_rd_i;
          ce_n_d = 1'b0;
          oe_d   = 4'b0001;
          dat_d  = {3'b000, QPI_WR[7]};
          cmd_d  = {QPI_WR[6:0], 1'b0};
          cnt_d  = '0;
        end
      end
      ST_CMD: begin
        if (sck_fall) begin
          if (cnt_q == 3'(CMD_BITS - 1)) begin
            oe_d   = 4'hF;
            dat_d  = addr_q[23:20];
            addr_d = {addr_q[19:0], 4'h0};
            cnt_d  = '0;
          end else begin
            dat_d = {3'b000, cmd_q[7]};
            cmd_d = {cmd_q[6:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_ADDR: begin
        if (sck_fall) begin
          if (cnt_q == 3'(ADDR_NIBS - 1)) begin
            dat_d = sr_q[31:28];
            sr_d  = {sr_q[27:0], 4'h0};
            cnt_d = '0;
            if (left_q != 10'd1) ra_d = ra_q + 9'd1;
          end else begin
            dat_d  = addr_q[23:20];
            addr_d = {addr_q[19:0], 4'h0};
            cnt_d  = cnt_q + 3'd1;
          end
        end
      end
      ST_DATA: begin
        if (sck_fall) begin
          if (cnt_q == 3'(WORD_NIBS - 1)) begin
            cnt_d = '0;
            if (left_q == 10'd1) begin
              ce_n_d = 1'b1;
              oe_d   = 4'h0;
              dat_d  = 4'h0;
              hold_d = '0;
            end else begin
              // Prefetched word has been stable on buf_rd_i for most of this word.
              left_d = left_q - 10'd1;
              dat_d  = buf_rd_i[31:28];
              sr_d   = {buf_rd_i[27:0], 4'h0};
              if (left_q > 10'd2) ra_d = ra_q + 9'd1;
            end
          end else begin
            dat_d = sr_q[31:28];
            sr_d  = {sr_q[27:0], 4'h0};
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_CSHI: begin
        if (hold_q == HW'(CS_HI - 1)) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      ce_n_q <= 1'b1;
      oe_q   <= 4'h0;
      dat_q  <= 4'h0;
      ra_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      left_q <= '0;
      hold_q <= '0;
    end else begin
      ce_n_q <= ce_n_d;
      oe_q   <= oe_d;
      dat_q  <= dat_d;
      ra_q   <= ra_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      left_q <= left_d;
      hold_q <= hold_d;
    end
  end

  always_ff @(posedge WBs_CLK_i) begin
    sr_q   <= sr_d;
    addr_q <= addr_d;
    cmd_q  <= cmd_d;
  end

  a_stable_on_rise : assert property (@(posedge WBs_CLK_i) disable iff (WBs_RST_i)
    sck_rise |-> (dat_d == dat_q && oe_d == oe_q && ce_n_d == ce_n_q));

  assign buf_ra_o    = ra_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign qspi_ce_n_o = ce_n_q;
  assign qspi_oe_o   = oe_q;
  assign qspi_dat_o  = dat_q;

endmodule

// File: tb/tb_qspi_sram_burst_writer.sv
// Directed bench for qspi_sram_burst_writer: two instances (CLK_DIV 1 and 3)
// driven from a vector table plus hand-written reset sequences.
module tb_qspi_sram_burst_writer;

  localparam int CS_HI = 2;

  typedef struct {
    int          sel;
    logic [23:0] base;
    logic [9:0]  n;
    int          fill;
    int          restart;
    int          exp_rises;
    int          exp_celow;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_r [2];
  logic [23:0] base;
  logic [9:0]  cnt;
  logic [31:0] mem [512];

  logic        ce_n_w [2];
  logic        sck_w  [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic [3:0]  oe_w   [2];
  logic [3:0]  dat_w  [2];
  logic [8:0]  ra_w   [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int DIV = (g == 0) ? 1 : 3;
    logic [31:0] rd;
    always @(posedge clk) rd <= mem[ra_w[g]];
    qspi_sram_burst_writer #(.CLK_DIV(DIV), .CS_HI(CS_HI)) dut (
      .WBs_CLK_i   (clk),
      .WBs_RST_i   (rst),
      .start_i     (start_r[g]),
      .base_addr_i (base),
      .word_cnt_i  (cnt),
      .buf_ra_o    (ra_w[g]),
      .buf_rd_i    (rd),
      .busy_o      (busy_w[g]),
      .done_o      (done_w[g]),
      .qspi_ce_n_o (ce_n_w[g]),
      .qspi_sck_o  (sck_w[g]),
      .qspi_oe_o   (oe_w[g]),
      .qspi_dat_o  (dat_w[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_mem(input int mode);
    for (int i = 0; i < 512; i++)
      mem[i] = (mode == 0) ? 32'(i) : (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    if (mode == 1) begin
      mem[0] = 32'h12345678;
      mem[1] = 32'h9ABCDEF0;
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input int g);
    chk({tag, "_ce_n"}, 32'(ce_n_w[g]), 32'd1);
    chk({tag, "_sck"},  32'(sck_w[g]),  32'd0);
    chk({tag, "_oe"},   32'(oe_w[g]),   32'd0);
    chk({tag, "_dat"},  32'(dat_w[g]),  32'd0);
    chk({tag, "_busy"}, 32'(busy_w[g]), 32'd0);
    chk({tag, "_done"}, 32'(done_w[g]), 32'd0);
    chk({tag, "_ra"},   32'(ra_w[g]),   32'd0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int g, period, rises, celow, gaps, last_rise, last_low, done_cyc, ramax, bad;
    bit busy_seen, got_done, valid;
    logic prev;
    logic [7:0] op;
    logic [7:0] rec[$];
    logic [7:0] exp[$];
    g = v.sel;
    period = (g == 0) ? 2 : 6;
    valid = (v.n >= 10'd1 && v.n <= 10'd512);
    fill_mem(v.fill);
    op = 8'h38;
    if (valid) begin
      for (int i = 0; i < 8; i++) exp.push_back({4'b0001, 3'b000, op[7-i]});
      for (int i = 0; i < 6; i++) exp.push_back({4'hF, 4'(v.base >> (20 - 4*i))});
      for (int w = 0; w < int'(v.n); w++)
        for (int k = 0; k < 8; k++) exp.push_back({4'hF, 4'(mem[w] >> (28 - 4*k))});
    end
    rises = 0; celow = 0; gaps = 0; last_rise = -1; last_low = 0;
    done_cyc = 0; ramax = 0; busy_seen = 0; got_done = 0; prev = 1'b0;
    @(negedge clk);
    base = v.base;
    cnt = v.n;
    start_r[g] = 1'b1;
    for (int c = 1; c <= 30000; c++) begin
      @(negedge clk);
      if (c == 1) chk({tag, "_busy_after_start"}, 32'(busy_w[g]), 32'(valid));
      if (busy_w[g]) busy_seen = 1;
      if (!ce_n_w[g]) begin
        celow++;
        last_low = c;
      end else begin
        last_rise = -1;
      end
      if (sck_w[g] && !prev) begin
        if (last_rise >= 0 && c - last_rise != period) gaps++;
        rises++;
        last_rise = c;
        rec.push_back({oe_w[g], dat_w[g]});
      end
      prev = sck_w[g];
      if (int'(ra_w[g]) > ramax) ramax = int'(ra_w[g]);
      start_r[g] = (c == v.restart);
      if (c == v.restart) begin
        base = 24'h777777;
        cnt = 10'd5;
      end
      if (done_w[g]) begin
        done_cyc = c;
        got_done = 1;
        break;
      end
    end
    start_r[g] = 1'b0;
    chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
    if (valid) chk({tag, "_cs_high_to_done"}, 32'(done_cyc - last_low), 32'(CS_HI + 1));
    else       chk({tag, "_done_latency"}, 32'(done_cyc), 32'd1);
    chk({tag, "_busy_seen"}, 32'(busy_seen), 32'(valid));
    chk({tag, "_rises"}, 32'(rises), 32'(v.exp_rises));
    chk({tag, "_ce_low_cycles"}, 32'(celow), 32'(v.exp_celow));
    chk({tag, "_sck_gaps"}, 32'(gaps), 32'd0);
    bad = (rec.size() == exp.size()) ? -1 : 0;
    if (bad < 0)
      foreach (exp[i]) if (bad < 0 && rec[i] !== exp[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s_stream: first bad index %0d, got %0h expected %0h (len %0d vs %0d)", tag, bad,
               (bad < rec.size()) ? rec[bad] : 8'hxx, (bad < exp.size()) ? exp[bad] : 8'hxx,
               rec.size(), exp.size());
    end
    if (valid) chk({tag, "_ra_max"}, 32'(ramax), 32'(int'(v.n) - 1));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done_w[g]), 32'd0);
    chk({tag, "_busy_after_done"}, 32'(busy_w[g]), 32'd0);
  endtask

  vec_t tbl [8];

  initial begin
    int r, dn;
    bit hit;
    logic prev;
    tbl[0] = '{0, 24'h000100, 10'd2,   1, 0,  30,   60};
    tbl[1] = '{0, 24'hABCDEF, 10'd1,   1, 0,  22,   44};
    tbl[2] = '{0, 24'h000000, 10'd0,   1, 0,  0,    0};
    tbl[3] = '{0, 24'h000000, 10'd600, 1, 0,  0,    0};
    tbl[4] = '{0, 24'hFEDCBA, 10'd5,   1, 12, 54,   108};
    tbl[5] = '{1, 24'h012345, 10'd3,   1, 0,  38,   228};
    tbl[6] = '{1, 24'h000000, 10'd512, 0, 0,  4110, 24660};
    tbl[7] = '{0, 24'hFFFFFF, 10'd512, 1, 0,  4110, 8220};

    rst = 1'b1;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    base = '0;
    cnt = '0;
    fill_mem(0);
    repeat (3) @(negedge clk);
    chk_idle_outputs("por_div1", 0);
    chk_idle_outputs("por_div3", 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec($sformatf("v%0d", i), tbl[i]);

    // Reset pulse while idle.
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_idle_outputs("idle_rst", 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset during the fourth data word: outputs drop at once, no done follows.
    fill_mem(1);
    @(negedge clk);
    base = 24'h0A0B0C;
    cnt = 10'd6;
    start_r[0] = 1'b1;
    r = 0; hit = 0; prev = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      start_r[0] = 1'b0;
      if (sck_w[0] && !prev) r++;
      prev = sck_w[0];
      if (r == 14 + 8*3 + 2) begin
        hit = 1;
        break;
      end
    end
    chk("midburst_reached_word3", 32'(hit), 32'd1);
    chk("midburst_ce_low_before_rst", 32'(ce_n_w[0]), 32'd0);
    #1 rst = 1'b1;
    #1 chk_idle_outputs("midburst_rst", 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done_w[0]) dn++;
    end
    chk("midburst_no_done", 32'(dn), 32'd0);
    chk("midburst_busy_low", 32'(busy_w[0]), 32'd0);
    run_vec("after_rst", tbl[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
